// File: rtl/rsa_const_unit.sv
// rsa_const_unit: computes Const = 2^(2*RBITS) mod M by shift-and-subtract, one step per enabled clock.
// Optional RSA_CONST_CACHE_EN skips recomputation when M repeats the last successfully processed modulus.
module rsa_const_unit #(
    parameter int WIDTH = 8,
    parameter int RBITS = 10
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] M,
    output logic [WIDTH-1:0] Const,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int CW = $clog2(2*RBITS+1);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH:0]   r;
    logic [WIDTH+1:0] t, t_red;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] m_q;
    logic             hit, last_step;
    assign t         = {r, 1'b0};
    assign t_red     = (t >= {2'b00, m_q}) ? t - {2'b00, m_q} : t;
    assign last_step = state == ITER && cnt == CW'(1);
    assign busy      = state != IDLE;
    assign done      = state == DONE;
`ifdef RSA_CONST_CACHE_EN
    logic             valid;
    logic [WIDTH-1:0] last_m;
    assign hit = valid && M == last_m;
    always_ff @(posedge clk) begin
        if (rstb) begin
            valid  <= 1'b0;
            last_m <= '0;
        end else if (en) begin
            if (state == IDLE && start && !M[0]) valid <= 1'b0;
            if (last_step) begin
                valid  <= 1'b1;
                last_m <= m_q;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif
    always_comb begin
        state_n = state;
        if (state == IDLE && start) state_n = (!M[0] || hit) ? DONE : ITER;
        else if (last_step) state_n = DONE;
        else if (state == DONE) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rstb) begin
            state <= IDLE;
            Const <= '0;
            err   <= 1'b0;
            r     <= '0;
            cnt   <= '0;
            m_q   <= '0;
        end else if (en) begin
            state <= state_n;
            if (state == IDLE && start) begin
                m_q <= M;
                err <= !M[0];
                if (!M[0]) Const <= '0;
                else if (!hit) begin
                    r   <= (M == WIDTH'(1)) ? '0 : (WIDTH+1)'(1);
                    cnt <= CW'(2*RBITS);
                end
            end else if (state == ITER) begin
                r   <= t_red[WIDTH:0];
                cnt <= cnt - CW'(1);
                if (last_step) Const <= t_red[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_rsa_const_unit.sv
// tb_rsa_const_unit: directed plus random checks of rsa_const_unit against an arithmetic model.
module tb_rsa_const_unit;
    localparam int RBITS = 10;
    logic       clk = 1'b0;
    logic       rstb, en, start;
    logic [7:0] M, Const;
    logic       busy, done, err;
    int         passed = 0, total = 0;
    logic [7:0] last_c = 8'h00;
    bit         cvalid = 1'b0;
    logic [7:0] cm = 8'h00;

    rsa_const_unit #(.WIDTH(8), .RBITS(RBITS)) dut (
        .clk(clk), .rstb(rstb), .en(en), .start(start), .M(M),
        .Const(Const), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] model(input logic [7:0] m);
        longint p = 1;
        if (!m[0]) return 8'h00;
        for (int i = 0; i < 2*RBITS; i++) p = (p * 2) % m;
        return p[7:0];
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_const"}, Const, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // lat counts edges from the start-sampling edge (inclusive) until done is visible
    task automatic run_op(input logic [7:0] m, input bit stall, input bit inject);
        int edges, lat;
        bit ev;
        logic [7:0] ec;
        ev  = !m[0];
        ec  = model(m);
        lat = ev ? 1 : 2*RBITS + 1;
`ifdef RSA_CONST_CACHE_EN
        if (!ev && cvalid && cm == m) lat = 1;
`endif
        if (stall) lat += 5;
        @(negedge clk);
        M = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        M = 8'($urandom);
        edges = 1;
        if (lat > 1) chk("const_held_at_start", Const, last_c);
        while (!done && edges < 200) begin
            chk("busy_during_iter", busy, 1);
            start = inject && edges == 3;
            if (inject && edges == 3) M = 8'h0D;
            if (stall && edges == 4) en = 1'b0;
            if (stall && edges == 9) en = 1'b1;
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("latency", edges, lat);
        chk("const", Const, ec);
        chk("err", err, ev);
        chk("busy_in_done", busy, 1);
        @(negedge clk);
        chk("done_pulse_end", done, 0);
        chk("busy_end", busy, 0);
        chk("const_hold", Const, ec);
        chk("err_hold", err, ev);
        last_c = ec;
        cvalid = !ev;
        if (!ev) cm = m;
    endtask

    initial begin
        bit seen;
        rstb = 1'b1; en = 1'b1; start = 1'b1; M = 8'hBB;
        repeat (2) begin
            @(negedge clk);
            check_idle_zero("reset");
        end
        rstb = 1'b0; start = 1'b0;
        run_op(8'hBB, 0, 0);
        run_op(8'hFF, 0, 0);
        run_op(8'h0D, 0, 0);
        run_op(8'h01, 0, 0);
        run_op(8'h40, 0, 0);
        run_op(8'h00, 0, 0);
        run_op(8'hBB, 1, 0);
        run_op(8'hBB, 0, 1);
        // abort: reset partway through the iterations must suppress done
        @(negedge clk);
        M = 8'hBB; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        rstb = 1'b0;
        check_idle_zero("abort");
        last_c = 8'h00; cvalid = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("no_done_after_abort", seen, 0);
        run_op(8'hBB, 0, 0);
        run_op(8'hBB, 0, 0);
        run_op(8'h40, 0, 0);
        run_op(8'hBB, 0, 0);
        for (int i = 0; i < 8; i++) run_op(8'($urandom_range(0, 255)), 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
